// File: rtl/md_unit_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Op codes and FSM states used by md_unit and the EX stage.
package md_unit_pkg;

   typedef enum logic [2:0] {
      MD_OP_NONE  = 3'b000,
      MD_OP_MULT  = 3'b001,
      MD_OP_MULTU = 3'b010,
      MD_OP_DIV   = 3'b011,
      MD_OP_DIVU  = 3'b100,
      MD_OP_MTHI  = 3'b101,
      MD_OP_MTLO  = 3'b110
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } md_state_e;

   function automatic logic op_signed(md_op_e op);
      return (op == MD_OP_MULT) || (op == MD_OP_DIV);
   endfunction

   function automatic logic op_div(md_op_e op);
      return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// Issue/result bundle between the EX stage and md_unit.
// master = EX side, slave = md_unit.
interface md_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       MDOp;
   logic [WIDTH-1:0] dInA;
   logic [WIDTH-1:0] dInB;
   logic             cancel;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, MDOp, dInA, dInB, cancel,
      input  busy, hi, lo
   );

   modport slave (
      input  start, MDOp, dInA, dInB, cancel,
      output busy, hi, lo
   );
endinterface

// File: rtl/md_unit_step.sv
// md_step: one radix-2 iteration of the shared datapath.
// Multiply = shift-add, divide = restoring subtract-shift.
module md_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   input  logic               is_div,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0]   sum;
   logic [2*WIDTH:0] sh;
   logic [WIDTH-1:0] diff;
   logic             ge;

   assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
               + (acc[0] ? {1'b0, operand} : '0);
   assign sh   = {acc, 1'b0};
   assign ge   = sh[2*WIDTH:WIDTH] >= {1'b0, operand};
   assign diff = sh[2*WIDTH-1:WIDTH] - operand;

   always_comb begin
      acc_next = {sum, acc[WIDTH-1:1]};
      if (is_div) begin
         if (ge)
            acc_next = {diff, sh[WIDTH-1:1], 1'b1};
         else
            acc_next = sh[2*WIDTH-1:0];
      end
   end

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative MULT/DIV with HI/LO, MTHI/MTLO and busy.
// MD_FAST_MULT_EN makes MULT/MULTU complete in the issue cycle.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic   clk,
   input logic   rst_n,
   md_unit_if.slave md
);

   md_state_e          state_q, state_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   md_op_e             op_q, op_d;
   logic               sa_q, sa_d, sb_q, sb_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

   md_op_e             op_in;
   logic               sgn_in;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               launch;

   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   quo, quo_s, rem, rem_s;

   assign op_in  = md_op_e'(md.MDOp);
   assign sgn_in = op_signed(op_in);
   assign a_mag  = (sgn_in && md.dInA[WIDTH-1]) ? -md.dInA : md.dInA;
   assign b_mag  = (sgn_in && md.dInB[WIDTH-1]) ? -md.dInB : md.dInB;

`ifdef MD_FAST_MULT_EN
   logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
   assign ext_a = {{WIDTH{sgn_in & md.dInA[WIDTH-1]}}, md.dInA};
   assign ext_b = {{WIDTH{sgn_in & md.dInB[WIDTH-1]}}, md.dInB};
   assign fast_prod = ext_a * ext_b;
`endif

   md_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc_q),
      .operand  (opnd_q),
      .is_div   (op_div(op_q)),
      .acc_next (acc_step)
   );

   // Magnitude results are corrected back to two's complement here.
   assign prod   = acc_q;
   assign prod_s = (sa_q ^ sb_q) ? -prod : prod;
   assign quo    = acc_q[WIDTH-1:0];
   assign rem    = acc_q[2*WIDTH-1:WIDTH];
   assign quo_s  = (sa_q ^ sb_q) ? -quo : quo;
   assign rem_s  = sa_q ? -rem : rem;

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      launch  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (md.start && !md.cancel) begin
               case (op_in)
                  MD_OP_MTHI: hi_d = md.dInA;
                  MD_OP_MTLO: lo_d = md.dInA;
                  MD_OP_MULT, MD_OP_MULTU: begin
`ifdef MD_FAST_MULT_EN
                     {hi_d, lo_d} = fast_prod;
`else
                     launch = 1'b1;
`endif
                  end
                  MD_OP_DIV, MD_OP_DIVU: launch = 1'b1;
                  default: ;
               endcase
            end
            if (launch) begin
               acc_d   = {{WIDTH{1'b0}}, a_mag};
               opnd_d  = b_mag;
               op_d    = op_in;
               sa_d    = sgn_in & md.dInA[WIDTH-1];
               sb_d    = sgn_in & md.dInB[WIDTH-1];
               dz_d    = (md.dInB == '0);
               cnt_d   = CNT_W'(WIDTH - 1);
               state_d = S_RUN;
               busy_d  = 1'b1;
            end
         end
         S_RUN: begin
            if (md.cancel) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               acc_d = acc_step;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == '0)
                  state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            if (!md.cancel) begin
               if (op_div(op_q)) begin
                  hi_d = rem_s;
                  lo_d = dz_q ? '1 : quo_s;
               end else begin
                  {hi_d, lo_d} = prod_s;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         op_q    <= MD_OP_NONE;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign md.busy = busy_q;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
// Expected values are hand-computed per scenario.
module tb_md_unit;

   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

`ifdef MD_FAST_MULT_EN
   localparam int MUL_CYC = 0;
`else
   localparam int MUL_CYC = 33;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   md_unit_if #(.WIDTH(32)) mif ();

   md_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .md    (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
      mif.start = 1'b1;
      mif.MDOp  = op;
      mif.dInA  = a;
      mif.dInB  = b;
      tick();
      mif.start = 1'b0;
      mif.MDOp  = OP_NONE;
   endtask

   task automatic run_op(input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output int cyc);
      issue(op, a, b);
      cyc = 0;
      while (mif.busy && cyc < 100) begin
         cyc++;
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      checks++;
      if (mif.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%0b want=0", mif.busy);
      end
      checks++;
      if (mif.hi !== 32'h0) begin
         failures++;
         $display("FAIL reset_hi got=%h want=0", mif.hi);
      end
      checks++;
      if (mif.lo !== 32'h0) begin
         failures++;
         $display("FAIL reset_lo got=%h want=0", mif.lo);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_multu();
      int cyc;
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
      checks++;
      if (cyc !== MUL_CYC) begin
         failures++;
         $display("FAIL multu_cycles got=%0d want=%0d", cyc, MUL_CYC);
      end
      checks++;
      if (mif.hi !== 32'hFFFF_FFFE || mif.lo !== 32'h0000_0001) begin
         failures++;
         $display("FAIL multu_result got=%h_%h want=fffffffe_00000001",
                  mif.hi, mif.lo);
      end
   endtask

   task automatic test_mult();
      int cyc;
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, cyc);
      checks++;
      if (cyc !== MUL_CYC) begin
         failures++;
         $display("FAIL mult_cycles got=%0d want=%0d", cyc, MUL_CYC);
      end
      checks++;
      if (mif.hi !== 32'hFFFF_FFFF || mif.lo !== 32'hFFFF_FFF1) begin
         failures++;
         $display("FAIL mult_result got=%h_%h want=ffffffff_fffffff1",
                  mif.hi, mif.lo);
      end
      run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, cyc);
      checks++;
      if (mif.hi !== 32'h4000_0000 || mif.lo !== 32'h0) begin
         failures++;
         $display("FAIL mult_minmin got=%h_%h want=40000000_00000000",
                  mif.hi, mif.lo);
      end
   endtask

   task automatic test_div();
      int cyc;
      logic [31:0] va [6];
      logic [31:0] vb [6];
      logic [2:0]  vo [6];
      logic [31:0] eh [6];
      logic [31:0] el [6];
      va[0] = 32'hFFFF_FFF9; vb[0] = 32'd2;        vo[0] = OP_DIV;
      eh[0] = 32'hFFFF_FFFF; el[0] = 32'hFFFF_FFFD;
      va[1] = 32'd7;         vb[1] = 32'd0;        vo[1] = OP_DIVU;
      eh[1] = 32'h7;         el[1] = 32'hFFFF_FFFF;
      va[2] = 32'h8000_0000; vb[2] = 32'hFFFF_FFFF; vo[2] = OP_DIV;
      eh[2] = 32'h0;         el[2] = 32'h8000_0000;
      va[3] = 32'd100;       vb[3] = 32'd7;        vo[3] = OP_DIVU;
      eh[3] = 32'd2;         el[3] = 32'd14;
      va[4] = 32'hFFFF_FFFB; vb[4] = 32'd0;        vo[4] = OP_DIV;
      eh[4] = 32'hFFFF_FFFB; el[4] = 32'hFFFF_FFFF;
      va[5] = 32'd7;         vb[5] = 32'hFFFF_FFFE; vo[5] = OP_DIV;
      eh[5] = 32'd1;         el[5] = 32'hFFFF_FFFD;
      for (int i = 0; i < 6; i++) begin
         run_op(vo[i], va[i], vb[i], cyc);
         checks++;
         if (cyc !== 33) begin
            failures++;
            $display("FAIL div_cycles[%0d] got=%0d want=33", i, cyc);
         end
         checks++;
         if (mif.hi !== eh[i] || mif.lo !== el[i]) begin
            failures++;
            $display("FAIL div_result[%0d] got=%h_%h want=%h_%h",
                     i, mif.hi, mif.lo, eh[i], el[i]);
         end
      end
   endtask

   task automatic test_mthi_mtlo();
      issue(OP_MTHI, 32'h0000_1234, 32'hDEAD_BEEF);
      issue(OP_MTLO, 32'h0000_5555, 32'h0);
      checks++;
      if (mif.busy !== 1'b0) begin
         failures++;
         $display("FAIL mt_busy got=%0b want=0", mif.busy);
      end
      checks++;
      if (mif.hi !== 32'h1234 || mif.lo !== 32'h5555) begin
         failures++;
         $display("FAIL mt_regs got=%h_%h want=00001234_00005555",
                  mif.hi, mif.lo);
      end
      issue(3'b111, 32'hFFFF_0000, 32'h0);
      checks++;
      if (mif.busy !== 1'b0 || mif.hi !== 32'h1234
          || mif.lo !== 32'h5555) begin
         failures++;
         $display("FAIL invalid_op got=%0b_%h_%h want=0_00001234_00005555",
                  mif.busy, mif.hi, mif.lo);
      end
   endtask

   task automatic test_cancel_run();
      issue(OP_DIVU, 32'd9, 32'd2);
      repeat (4) tick();
      issue(OP_MTHI, 32'hDEAD_0000, 32'h0);
      repeat (4) tick();
      checks++;
      if (mif.busy !== 1'b1 || mif.hi !== 32'h1234) begin
         failures++;
         $display("FAIL start_while_busy got=%0b_%h want=1_00001234",
                  mif.busy, mif.hi);
      end
      mif.cancel = 1'b1;
      tick();
      mif.cancel = 1'b0;
      checks++;
      if (mif.busy !== 1'b0) begin
         failures++;
         $display("FAIL cancel_run_busy got=%0b want=0", mif.busy);
      end
      repeat (40) tick();
      checks++;
      if (mif.busy !== 1'b0 || mif.hi !== 32'h1234
          || mif.lo !== 32'h5555) begin
         failures++;
         $display("FAIL cancel_run_regs got=%0b_%h_%h want=0_00001234_00005555",
                  mif.busy, mif.hi, mif.lo);
      end
   endtask

   task automatic test_cancel_fix();
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (32) tick();
      checks++;
      if (mif.busy !== 1'b1) begin
         failures++;
         $display("FAIL fix_busy got=%0b want=1", mif.busy);
      end
      mif.cancel = 1'b1;
      tick();
      mif.cancel = 1'b0;
      checks++;
      if (mif.busy !== 1'b0 || mif.hi !== 32'h1234
          || mif.lo !== 32'h5555) begin
         failures++;
         $display("FAIL cancel_fix got=%0b_%h_%h want=0_00001234_00005555",
                  mif.busy, mif.hi, mif.lo);
      end
   endtask

   task automatic test_cancel_idle();
      mif.cancel = 1'b1;
      issue(OP_MTHI, 32'h9999, 32'h0);
      issue(OP_DIVU, 32'd8, 32'd2);
      mif.cancel = 1'b0;
      checks++;
      if (mif.busy !== 1'b0 || mif.hi !== 32'h1234) begin
         failures++;
         $display("FAIL cancel_idle got=%0b_%h want=0_00001234",
                  mif.busy, mif.hi);
      end
   endtask

   task automatic test_reset_mid();
      issue(OP_MULT, 32'd1000, 32'd3000);
      repeat (19) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (mif.busy !== 1'b0 || mif.hi !== 32'h0 || mif.lo !== 32'h0) begin
         failures++;
         $display("FAIL reset_mid got=%0b_%h_%h want=0_0_0",
                  mif.busy, mif.hi, mif.lo);
      end
      tick();
      rst_n = 1'b1;
      tick();
      repeat (40) tick();
      checks++;
      if (mif.busy !== 1'b0 || mif.hi !== 32'h0 || mif.lo !== 32'h0) begin
         failures++;
         $display("FAIL reset_no_write got=%0b_%h_%h want=0_0_0",
                  mif.busy, mif.hi, mif.lo);
      end
      issue(OP_MTHI, 32'h77, 32'h0);
      issue(OP_MTLO, 32'h88, 32'h0);
      checks++;
      if (mif.hi !== 32'h77 || mif.lo !== 32'h88) begin
         failures++;
         $display("FAIL after_reset_mt got=%h_%h want=00000077_00000088",
                  mif.hi, mif.lo);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      run_op(OP_DIVU, 32'd100, 32'd7, cyc);
      run_op(OP_MULTU, 32'd3, 32'd4, cyc);
      checks++;
      if (cyc !== MUL_CYC) begin
         failures++;
         $display("FAIL b2b_cycles got=%0d want=%0d", cyc, MUL_CYC);
      end
      checks++;
      if (mif.hi !== 32'h0 || mif.lo !== 32'd12) begin
         failures++;
         $display("FAIL b2b_result got=%h_%h want=00000000_0000000c",
                  mif.hi, mif.lo);
      end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst_n      = 1'b0;
      mif.start  = 1'b0;
      mif.MDOp   = OP_NONE;
      mif.dInA   = '0;
      mif.dInB   = '0;
      mif.cancel = 1'b0;
      #1;
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_cancel_run();
      test_cancel_fix();
      test_cancel_idle();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit for the MIPS pipeline, sitting beside the ALU in EX.
- Sequences a shared shift/add-subtract datapath for MULT, MULTU, DIV and DIVU. Owns the HI/LO registers and services MTHI/MTLO.
- Exposes a busy flag. The hazard logic uses it to stall the pipeline when a new MD op or an MFHI/MFLO arrives during an operation.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  issue request from EX, qualified by op
- MDOp  in  3  operation code (encodings in declarations.v)
- dInA  in  WIDTH  R[rs]: multiplicand / dividend / MTHI-MTLO source
- dInB  in  WIDTH  R[rt]: multiplier / divisor
- cancel  in  1  abort the in-flight op (exception or flush)
- busy  out  1  operation in progress (registered)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, hi=0, lo=0, counter=0, work regs=0.
- States: IDLE, RUN, FIX.
- IDLE:
  - start is sampled only in IDLE. start with MDOp none/invalid is ignored.
  - MTHI/MTLO: hi (or lo) <= dInA at that edge; stay in IDLE; busy stays 0.
  - MULT/MULTU/DIV/DIVU: latch operand magnitudes, signed ops take abs values. Latch sign flags and op; counter <= WIDTH-1; go to RUN; busy <= 1.
- RUN:
  - One radix-2 step per cycle. Multiply: shift-add over a 2*WIDTH accumulator. Divide: restoring subtract-shift.
  - counter decrements each cycle; at 0 go to FIX.
- FIX:
  - Single cycle. Apply sign correction and write hi/lo; go to IDLE; busy <= 0.
  - Result ops: mult: {hi,lo} = 64-bit product. div: lo = quotient, hi = remainder.
  - Signed quotient sign = sA^sB; remainder sign = sign of dividend.
- Latency: busy is high for exactly WIDTH+1 = 33 cycles, starting the edge after start. hi/lo hold the new result in the first cycle busy is low.
- Operand width: all arithmetic is mod 2^WIDTH per half. 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Divide by zero (signed or unsigned): hi = dInA as latched, lo = all ones. Detected at start; the unit still runs the full 33 cycles.
- start while busy: ignored. The pipeline must hold the instruction via stall, because no queueing is done.
- cancel:
  - In RUN/FIX: go to IDLE next edge, busy <= 0, hi/lo unchanged.
  - cancel with start in IDLE: start ignored (cancel wins).
  - cancel has priority over the FIX write.
- Reset mid-operation: immediate return to reset values; no partial write.
- hi/lo change only on MTHI/MTLO in IDLE, or in FIX.

Optional Feature:
- Macro: MD_FAST_MULT_EN.
- Defined: MULT/MULTU finish single-cycle. {hi,lo} <= full product at the start edge, busy never asserts, state stays IDLE. DIV/DIVU are unchanged (33 cycles).
- Undefined: all four ops use the iterative path and the 33-cycle busy window.
- cancel/reset rules apply identically in both builds.

Decomposition:
- declarations.v gets:
  - MDOp encodings: MD_op_none=3'b000, MD_op_mult=001, MD_op_multu=010, MD_op_div=011, MD_op_divu=100, MD_op_mthi=101, MD_op_mtlo=110.
  - MD state encodings: IDLE=2'b00, RUN=2'b01, FIX=2'b10.
- Sub-module md_step: a combinational single-iteration datapath. Inputs: accumulator, operand, is_div. Output: next accumulator. Instantiated once; md_unit holds the FSM, counter and registers.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> busy high 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
- mult -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. With MD_FAST_MULT_EN: same values the next cycle, busy never high.
- div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7 / 0 -> hi=0x00000007, lo=0xFFFFFFFF.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. divu 100 / 7 -> lo=14, hi=2.
- mthi 0x1234 then divu 9/2. Assert cancel on cycle 10 of RUN -> busy drops next edge, hi=0x1234, lo unchanged. A start pulsed mid-run is ignored.
- Start mult, then pull rst_n low at cycle 20 -> busy=0, hi=lo=0 immediately. A fresh mthi/mtlo after release works.
